// File: rtl/m72_mixer_pkg.sv
// m72_mixer_pkg: shared types for the M72 layer mixer (control word, palette index, layer taps).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package m72_mixer_pkg;

  typedef enum logic [1:0] {
    SRC_SPR = 2'b00,
    SRC_A   = 2'b01,
    SRC_B   = 2'b10,
    SRC_BD  = 2'b11
  } src_t;

  // Control word as seen by the CPU; bit 0 is DLY_A[0]
  typedef struct packed {
    logic [3:0] rsvd;   // [15:12]
    logic [1:0] solo;   // [11:10], only writable with M72_MIXER_SOLO_EN
    logic       swap;   // [9]  B in front of A
    logic       en_s;   // [8]
    logic       en_b;   // [7]
    logic       en_a;   // [6]
    logic [2:0] dly_b;  // [5:3]
    logic [2:0] dly_a;  // [2:0]
  } ctrl_t;

  localparam ctrl_t CTRL_RESET = ctrl_t'(16'h01C0);

`ifdef M72_MIXER_SOLO_EN
  localparam logic [15:0] CTRL_MASK = 16'h0FFF;
`else
  localparam logic [15:0] CTRL_MASK = 16'h03FF;
`endif

  typedef struct packed {
    src_t       src;
    logic [3:0] col;
    logic [3:0] pix;
  } pal_idx_t;

  // Layer A tuple carried through its delay line
  typedef struct packed {
    logic       pri;
    logic [3:0] col;
    logic [3:0] pix;
  } a_tap_t;

  // Layer B tuple carried through its delay line
  typedef struct packed {
    logic [3:0] col;
    logic [3:0] pix;
  } b_tap_t;

endpackage

// File: rtl/m72_layer_mixer_if.sv
// m72_layer_mixer_if: pixel inputs, CPU control port and palette outputs of the layer mixer.
// Latency: n/a (wiring only).
// Backpressure: none; pixel traffic is paced by CE_PIX alone.
interface m72_layer_mixer_if;
  logic        CE_PIX;
  logic [3:0]  A_BIT;
  logic [3:0]  A_COL;
  logic        A_PRI;
  logic [3:0]  B_BIT;
  logic [3:0]  B_COL;
  logic [7:0]  S_PIX;
  logic        HBLANK;
  logic        VBLANK;
  logic        CTRL_WR;
  logic [15:0] CTRL_DIN;
  logic [1:0]  BYTE_SEL;
  logic [9:0]  PAL_IDX;
  logic        BLANK;
  logic [15:0] CTRL_DOUT;

  modport master (
    output CE_PIX, A_BIT, A_COL, A_PRI, B_BIT, B_COL, S_PIX, HBLANK, VBLANK,
    output CTRL_WR, CTRL_DIN, BYTE_SEL,
    input  PAL_IDX, BLANK, CTRL_DOUT
  );

  modport slave (
    input  CE_PIX, A_BIT, A_COL, A_PRI, B_BIT, B_COL, S_PIX, HBLANK, VBLANK,
    input  CTRL_WR, CTRL_DIN, BYTE_SEL,
    output PAL_IDX, BLANK, CTRL_DOUT
  );
endinterface

// File: rtl/m72_pix_delay.sv
// m72_pix_delay: DEPTH-deep pixel shift line with selectable output tap (0 = bypass).
// Latency: sel pixel beats; tap values above DEPTH clamp to DEPTH.
// Backpressure: none; shifts only on ce, contents survive tap changes.
module m72_pix_delay #(
  parameter int W     = 9,
  parameter int DEPTH = 7,
  parameter int SEL_W = 3
) (
  input  logic             CLK_32M,
  input  logic             RESET_N,
  input  logic             ce,
  input  logic [W-1:0]     din,
  input  logic [SEL_W-1:0] sel,
  output logic [W-1:0]     dout
);

  logic [DEPTH-1:0][W-1:0] line_q;

  // Shift line: entry i holds the pixel from i+1 beats ago
  always_ff @(posedge CLK_32M or negedge RESET_N) begin
    if (!RESET_N) begin
      line_q <= '0;
    end else if (ce) begin
      line_q[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        line_q[i] <= line_q[i-1];
      end
    end
  end

  // Tap select; anything past the end of the line reads the last entry
  always_comb begin
    dout = din;
    for (int i = 1; i <= DEPTH; i++) begin
      if ((int'(sel) == i) || ((i == DEPTH) && (int'(sel) > DEPTH))) begin
        dout = line_q[i-1];
      end
    end
  end

endmodule

// File: rtl/m72_layer_mixer.sv
// m72_layer_mixer: aligns tile layers A/B and sprites, resolves priority, outputs a palette index.
// Latency: 3 CE_PIX beats for sprite and blank, 3 + DLY_x beats for tile layer x.
// Backpressure: none; all pixel-path registers advance on CE_PIX and hold while it is low.
// Optional feature macro: M72_MIXER_SOLO_EN (SOLO field in control bits [11:10]).
module m72_layer_mixer
  import m72_mixer_pkg::*;
#(
  parameter int         MAX_DLY      = 7,
  parameter logic [9:0] BACKDROP_IDX = 10'h3F0
) (
  input logic              CLK_32M,
  input logic              RESET_N,
  m72_layer_mixer_if.slave bus
);

  ctrl_t      shadow_q, shadow_nx, active_q;
  logic       vb_prev_q;
  logic       copy_en;

  a_tap_t     s0_a, a_d;
  b_tap_t     s0_b, b_d;
  logic [7:0] s0_s;
  logic       s0_blank;

  logic       op_a, op_b, op_s;
  pal_idx_t   res;
  logic [9:0] s1_idx;
  logic       s1_blank;
  logic [9:0] pal_q;
  logic       blank_q;

  // Shadow next value: byte-lane write, unimplemented bits always read zero
  always_comb begin
    shadow_nx = shadow_q;
    if (bus.CTRL_WR) begin
      if (bus.BYTE_SEL[0]) shadow_nx[7:0]  = bus.CTRL_DIN[7:0];
      if (bus.BYTE_SEL[1]) shadow_nx[15:8] = bus.CTRL_DIN[15:8];
    end
    shadow_nx = ctrl_t'(shadow_nx & CTRL_MASK);
  end

  // Copy happens on the first pixel beat of vertical blank; the edge flag
  // resets high so a VBLANK already asserted at reset release is not an edge
  assign copy_en = bus.CE_PIX & bus.VBLANK & ~vb_prev_q;

  // Control registers; a same-cycle write lands in the copy via shadow_nx
  always_ff @(posedge CLK_32M or negedge RESET_N) begin
    if (!RESET_N) begin
      shadow_q  <= CTRL_RESET;
      active_q  <= CTRL_RESET;
      vb_prev_q <= 1'b1;
    end else begin
      shadow_q <= shadow_nx;
      if (copy_en) active_q <= shadow_nx;
      if (bus.CE_PIX) vb_prev_q <= bus.VBLANK;
    end
  end

  // Stage 0: capture all pixel inputs and the combined blank
  always_ff @(posedge CLK_32M or negedge RESET_N) begin
    if (!RESET_N) begin
      s0_a     <= '0;
      s0_b     <= '0;
      s0_s     <= '0;
      s0_blank <= 1'b1;
    end else if (bus.CE_PIX) begin
      s0_a     <= '{pri: bus.A_PRI, col: bus.A_COL, pix: bus.A_BIT};
      s0_b     <= '{col: bus.B_COL, pix: bus.B_BIT};
      s0_s     <= bus.S_PIX;
      s0_blank <= bus.HBLANK | bus.VBLANK;
    end
  end

  m72_pix_delay #(
    .W     ($bits(a_tap_t)),
    .DEPTH (MAX_DLY),
    .SEL_W (3)
  ) u_dly_a (
    .CLK_32M (CLK_32M),
    .RESET_N (RESET_N),
    .ce      (bus.CE_PIX),
    .din     (s0_a),
    .sel     (active_q.dly_a),
    .dout    (a_d)
  );

  m72_pix_delay #(
    .W     ($bits(b_tap_t)),
    .DEPTH (MAX_DLY),
    .SEL_W (3)
  ) u_dly_b (
    .CLK_32M (CLK_32M),
    .RESET_N (RESET_N),
    .ce      (bus.CE_PIX),
    .din     (s0_b),
    .sel     (active_q.dly_b),
    .dout    (b_d)
  );

  // Priority resolve: A-priority tiles, then sprites, then front tile, then back tile
  always_comb begin
    op_a = active_q.en_a & (a_d.pix != 4'd0);
    op_b = active_q.en_b & (b_d.pix != 4'd0);
    op_s = active_q.en_s & (s0_s[3:0] != 4'd0);
    res  = pal_idx_t'(BACKDROP_IDX);
    // With SWAP set and B opaque, B must stay in front, so A priority is dropped
    if (op_a && a_d.pri && !(active_q.swap && op_b)) begin
      res = '{src: SRC_A, col: a_d.col, pix: a_d.pix};
    end else if (op_s) begin
      res = '{src: SRC_SPR, col: s0_s[7:4], pix: s0_s[3:0]};
    end else if (active_q.swap ? op_b : op_a) begin
      res = active_q.swap ? '{src: SRC_B, col: b_d.col, pix: b_d.pix}
                          : '{src: SRC_A, col: a_d.col, pix: a_d.pix};
    end else if (active_q.swap ? op_a : op_b) begin
      res = active_q.swap ? '{src: SRC_A, col: a_d.col, pix: a_d.pix}
                          : '{src: SRC_B, col: b_d.col, pix: b_d.pix};
    end
`ifdef M72_MIXER_SOLO_EN
    // Solo overrides the normal stack: only one layer is looked at, tagged src 11
    if (active_q.solo != 2'b00) begin
      res = pal_idx_t'(BACKDROP_IDX);
      case (active_q.solo)
        2'b01:   if (op_a) res = '{src: SRC_BD, col: a_d.col, pix: a_d.pix};
        2'b10:   if (op_b) res = '{src: SRC_BD, col: b_d.col, pix: b_d.pix};
        default: if (op_s) res = '{src: SRC_BD, col: s0_s[7:4], pix: s0_s[3:0]};
      endcase
    end
`endif
  end

  // Stage 1 (resolved index) and stage 2 (output, backdrop forced in blank)
  always_ff @(posedge CLK_32M or negedge RESET_N) begin
    if (!RESET_N) begin
      s1_idx   <= BACKDROP_IDX;
      s1_blank <= 1'b1;
      pal_q    <= BACKDROP_IDX;
      blank_q  <= 1'b1;
    end else if (bus.CE_PIX) begin
      s1_idx   <= res;
      s1_blank <= s0_blank;
      pal_q    <= s1_blank ? BACKDROP_IDX : s1_idx;
      blank_q  <= s1_blank;
    end
  end

  // Reserved bits (and SOLO when the feature is absent) have no consumer
  logic ctrl_unused;
  assign ctrl_unused = ^{active_q.rsvd, active_q.solo};

  assign bus.PAL_IDX   = pal_q;
  assign bus.BLANK     = blank_q;
  assign bus.CTRL_DOUT = shadow_q;

endmodule

// File: tb/tb_m72_layer_mixer.sv
// tb_m72_layer_mixer: directed plus randomized checks of the layer mixer against a beat-history model.
// Latency: model predicts output after each CE beat from input history and active control.
// Backpressure: n/a.
module tb_m72_layer_mixer;

  localparam int         MAX_DLY = 4;
  localparam logic [9:0] BD      = 10'h3F0;
`ifdef M72_MIXER_SOLO_EN
  localparam logic [15:0] WMASK     = 16'h0FFF;
  localparam logic [15:0] HI_FF_EXP = 16'h0FC0;
`else
  localparam logic [15:0] WMASK     = 16'h03FF;
  localparam logic [15:0] HI_FF_EXP = 16'h03C0;
`endif

  logic CLK_32M = 1'b0;
  logic RESET_N = 1'b1;

  m72_layer_mixer_if bus();

  m72_layer_mixer #(
    .MAX_DLY      (MAX_DLY),
    .BACKDROP_IDX (BD)
  ) dut (
    .CLK_32M (CLK_32M),
    .RESET_N (RESET_N),
    .bus     (bus.slave)
  );

  always #5 CLK_32M = ~CLK_32M;

  typedef struct {
    logic [3:0] a_bit, a_col;
    logic       a_pri;
    logic [3:0] b_bit, b_col;
    logic [7:0] s_pix;
    logic       blank;
  } px_t;

  // Model state: per-beat input history and the active control in force at each beat
  px_t         hist     [16];
  logic [15:0] act_hist [16];
  int unsigned beat;
  logic [15:0] m_shadow, m_active;
  logic        m_vbprev;
  logic [9:0]  exp_pal;
  logic        exp_blank;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected {blank, index} from control word c, sprite/blank entry s, layer entries a, b
  function automatic logic [10:0] ref_out(input logic [15:0] c, input px_t s, input px_t a, input px_t b);
    logic       opa, opb, ops;
    logic [9:0] pa, pb, idx;
    opa = c[6] && (a.a_bit != 4'd0);
    opb = c[7] && (b.b_bit != 4'd0);
    ops = c[8] && (s.s_pix[3:0] != 4'd0);
    pa  = {2'b01, a.a_col, a.a_bit};
    pb  = {2'b10, b.b_col, b.b_bit};
    idx = BD;
    if (opa && a.a_pri && !(c[9] && opb)) idx = pa;
    else if (ops)                         idx = {2'b00, s.s_pix};
    else if (c[9])                        idx = opb ? pb : (opa ? pa : BD);
    else                                  idx = opa ? pa : (opb ? pb : BD);
`ifdef M72_MIXER_SOLO_EN
    if (c[11:10] == 2'd1) idx = opa ? {2'b11, a.a_col, a.a_bit} : BD;
    if (c[11:10] == 2'd2) idx = opb ? {2'b11, b.b_col, b.b_bit} : BD;
    if (c[11:10] == 2'd3) idx = ops ? {2'b11, s.s_pix} : BD;
`endif
    if (s.blank) idx = BD;
    return {s.blank, idx};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      hist[i]       = '{default: '0};
      hist[i].blank = 1'b1;
      act_hist[i]   = 16'h01C0;
    end
    m_shadow  = 16'h01C0;
    m_active  = 16'h01C0;
    m_vbprev  = 1'b1;
    exp_pal   = BD;
    exp_blank = 1'b1;
    beat      = 16;
  endtask

  // Advance the model by one clock edge using the inputs currently on the bus
  task automatic model_edge();
    logic [15:0] sh_nx, c;
    px_t         cur;
    int          da, db;
    logic [10:0] r;
    sh_nx = m_shadow;
    if (bus.CTRL_WR) begin
      if (bus.BYTE_SEL[0]) sh_nx[7:0]  = bus.CTRL_DIN[7:0];
      if (bus.BYTE_SEL[1]) sh_nx[15:8] = bus.CTRL_DIN[15:8];
      sh_nx = sh_nx & WMASK;
    end
    if (bus.CE_PIX) begin
      cur.a_bit = bus.A_BIT;  cur.a_col = bus.A_COL;  cur.a_pri = bus.A_PRI;
      cur.b_bit = bus.B_BIT;  cur.b_col = bus.B_COL;  cur.s_pix = bus.S_PIX;
      cur.blank = bus.HBLANK | bus.VBLANK;
      hist[beat % 16]     = cur;
      act_hist[beat % 16] = m_active;
      c  = act_hist[(beat - 1) % 16];
      da = (int'(c[2:0]) > MAX_DLY) ? MAX_DLY : int'(c[2:0]);
      db = (int'(c[5:3]) > MAX_DLY) ? MAX_DLY : int'(c[5:3]);
      r  = ref_out(c, hist[(beat - 2) % 16], hist[(beat - 2 - da) % 16], hist[(beat - 2 - db) % 16]);
      exp_blank = r[10];
      exp_pal   = r[9:0];
      if (bus.VBLANK && !m_vbprev) m_active = sh_nx;
      m_vbprev = bus.VBLANK;
      beat++;
    end
    m_shadow = sh_nx;
  endtask

  // One clock: model on the rising edge, compare on the falling edge
  task automatic tick();
    @(posedge CLK_32M);
    if (RESET_N) model_edge();
    @(negedge CLK_32M);
    chk("pal_idx", bus.PAL_IDX, exp_pal);
    chk("blank", bus.BLANK, exp_blank);
    chk("ctrl_dout", bus.CTRL_DOUT, m_shadow);
    bus.CTRL_WR = 1'b0;
    bus.CE_PIX  = 1'b0;
  endtask

  // n pixel beats with CE_PIX every 4th clock
  task automatic beats(input int n);
    repeat (n) begin
      repeat (3) tick();
      bus.CE_PIX = 1'b1;
      tick();
    end
  endtask

  task automatic ctrl_write(input logic [15:0] d, input logic [1:0] sel);
    bus.CTRL_WR  = 1'b1;
    bus.CTRL_DIN = d;
    bus.BYTE_SEL = sel;
    tick();
  endtask

  task automatic set_px(input logic [3:0] ab, input logic [3:0] ac, input logic ap,
                        input logic [3:0] bb, input logic [3:0] bc, input logic [7:0] sp);
    bus.A_BIT = ab; bus.A_COL = ac; bus.A_PRI = ap;
    bus.B_BIT = bb; bus.B_COL = bc; bus.S_PIX = sp;
  endtask

  task automatic vblank_pulse();
    bus.VBLANK = 1'b1;
    beats(1);
    bus.VBLANK = 1'b0;
  endtask

  function automatic logic [3:0] rnib();
    return ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
  endfunction

  initial begin
    bus.CE_PIX = 1'b0; bus.HBLANK = 1'b0; bus.VBLANK = 1'b0;
    bus.CTRL_WR = 1'b0; bus.CTRL_DIN = '0; bus.BYTE_SEL = '0;
    set_px(0, 0, 0, 0, 0, 8'h00);

    // Reset state
    #1 RESET_N = 1'b0;
    model_reset();
    #1;
    chk("rst_pal", bus.PAL_IDX, 10'h3F0);
    chk("rst_blank", bus.BLANK, 1'b1);
    chk("rst_ctrl", bus.CTRL_DOUT, 16'h01C0);
    repeat (2) @(negedge CLK_32M);
    RESET_N = 1'b1;

    // Sprite only: 3-beat latency, blank follows HBLANK with the same latency
    set_px(0, 0, 0, 0, 0, 8'h35);
    beats(2);
    chk("spr_lat2_blank", bus.BLANK, 1'b1);
    beats(1);
    chk("spr_lat3_pal", bus.PAL_IDX, 10'h035);
    chk("spr_lat3_blank", bus.BLANK, 1'b0);
    bus.HBLANK = 1'b1;
    beats(2);
    chk("hbl_lat2", bus.BLANK, 1'b0);
    beats(1);
    chk("hbl_lat3_blank", bus.BLANK, 1'b1);
    chk("hbl_lat3_pal", bus.PAL_IDX, 10'h3F0);
    bus.HBLANK = 1'b0;
    beats(3);

    // A priority over sprite, and sprite over A without priority
    set_px(4'd2, 4'd5, 1'b1, 0, 0, 8'h35);
    beats(3);
    chk("a_pri", bus.PAL_IDX, 10'h152);
    bus.A_PRI = 1'b0;
    beats(3);
    chk("a_nopri", bus.PAL_IDX, 10'h035);

    // SWAP + sprite off takes effect only after the VBLANK rising beat
    ctrl_write(16'h02C0, 2'b11);
    chk("wr_readback", bus.CTRL_DOUT, 16'h02C0);
    set_px(4'd2, 4'd5, 1'b0, 4'd4, 4'd7, 8'h35);
    beats(3);
    chk("pre_copy", bus.PAL_IDX, 10'h035);
    vblank_pulse();
    beats(3);
    chk("post_copy_swap", bus.PAL_IDX, 10'h274);

    // DLY_A = 3: single-beat A impulse appears 6 beats later
    ctrl_write(16'h00C3, 2'b11);
    set_px(0, 0, 0, 0, 0, 8'h00);
    vblank_pulse();
    beats(6);
    set_px(4'd2, 4'd5, 1'b0, 0, 0, 8'h00);
    beats(1);
    set_px(0, 0, 0, 0, 0, 8'h00);
    beats(4);
    chk("dly3_before", bus.PAL_IDX, 10'h3F0);
    beats(1);
    chk("dly3_hit", bus.PAL_IDX, 10'h152);

    // DLY_A = 7 clamps to MAX_DLY = 4: impulse appears 7 beats later
    ctrl_write(16'h00C7, 2'b11);
    vblank_pulse();
    beats(6);
    set_px(4'd2, 4'd5, 1'b0, 0, 0, 8'h00);
    beats(1);
    set_px(0, 0, 0, 0, 0, 8'h00);
    beats(5);
    chk("dly_clamp_before", bus.PAL_IDX, 10'h3F0);
    beats(1);
    chk("dly_clamp_hit", bus.PAL_IDX, 10'h152);

    // Mid-line reset: outputs go to backdrop/blank at once
    set_px(4'd2, 4'd5, 1'b0, 0, 0, 8'h00);
    beats(8);
    chk("pre_rst_pal", bus.PAL_IDX, 10'h152);
    RESET_N = 1'b0;
    model_reset();
    #1;
    chk("midrst_pal", bus.PAL_IDX, 10'h3F0);
    chk("midrst_blank", bus.BLANK, 1'b1);
    chk("midrst_ctrl", bus.CTRL_DOUT, 16'h01C0);
    repeat (2) @(negedge CLK_32M);
    bus.VBLANK = 1'b1;
    RESET_N = 1'b1;

    // Upper byte-lane write keeps the lower byte; reserved bits read 0
    ctrl_write(16'hFFFF, 2'b10);
    chk("byte_lane", bus.CTRL_DOUT, HI_FF_EXP);
    ctrl_write(16'h03C0, 2'b11);

    // VBLANK held through reset release is not an edge: no copy, A stays in front
    set_px(4'd2, 4'd5, 1'b0, 4'd4, 4'd7, 8'h00);
    beats(2);
    bus.VBLANK = 1'b0;
    beats(3);
    chk("no_copy_after_rst", bus.PAL_IDX, 10'h152);
    vblank_pulse();
    beats(3);
    chk("copy_after_edge", bus.PAL_IDX, 10'h274);

    // Write in the same cycle as the copy beat is included in the copy
    bus.VBLANK = 1'b1;
    repeat (3) tick();
    bus.CE_PIX   = 1'b1;
    bus.CTRL_WR  = 1'b1;
    bus.CTRL_DIN = 16'h01C0;
    bus.BYTE_SEL = 2'b11;
    tick();
    bus.VBLANK = 1'b0;
    beats(3);
    chk("wr_during_copy", bus.PAL_IDX, 10'h152);

    // Randomized traffic: irregular CE, blanks, control writes
    for (int n = 0; n < 6000; n++) begin
      bus.CE_PIX = ($urandom_range(0, 2) == 0);
      if (bus.CE_PIX) begin
        set_px(rnib(), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
               rnib(), 4'($urandom_range(0, 15)), {4'($urandom_range(0, 15)), rnib()});
        if ($urandom_range(0, 15) == 0) bus.HBLANK = ~bus.HBLANK;
        if ($urandom_range(0, 12) == 0) bus.VBLANK = ~bus.VBLANK;
      end
      if ($urandom_range(0, 30) == 0) begin
        bus.CTRL_WR  = 1'b1;
        bus.CTRL_DIN = 16'($urandom);
        bus.BYTE_SEL = 2'($urandom_range(0, 3));
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
